filter_select_ctrl: RTL

- Control stage directly upstream of the filter block.
- Turns raw, asynchronous push-buttons into a registered filters_en level and one-cycle select0..select3 pulses, which feed the filter block's enable/select inputs.
- Owns synchronisation, debouncing, edge detection and the filter-selection state.
- Also exposes the current selection for on-screen display.

---
 rtl/filter_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/filter_select_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared filter codes, selection width and control FSM state type.
// Also used by the filter block so both ends agree on filter numbering.
package filter_pkg;

  localparam int unsigned FILTER_SEL_W = 2;
  localparam int unsigned NUM_FILTERS  = 4;

  localparam logic [FILTER_SEL_W-1:0] SEPIA  = 2'd0;
  localparam logic [FILTER_SEL_W-1:0] INVERT = 2'd1;
  localparam logic [FILTER_SEL_W-1:0] FILT2  = 2'd2;
  localparam logic [FILTER_SEL_W-1:0] FILT3  = 2'd3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } fsm_state_e;

  function automatic logic [NUM_FILTERS-1:0] sel_onehot(input logic [FILTER_SEL_W-1:0] code);
    logic [NUM_FILTERS-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter and a
// registered one-cycle press strobe on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic strobe
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic            armed_q;
  logic            strobe_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // The synchroniser resets to "pressed" and strobes stay disarmed until a
  // low has been seen, so a button held through reset never strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      level_q  <= 1'b0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      prev_q   <= level_q;
      armed_q  <= armed_q | ~sync_q[1];
      strobe_q <= armed_q & level_q & ~prev_q;
    end
  end

  assign level  = level_q;
  assign strobe = strobe_q;

endmodule

// File: rtl/filter_select_ctrl.sv
// Button-driven filter enable/selection controller feeding the filter block.
// Optional FILTER_AUTO_CYCLE_EN adds a timed auto-advance of the selection.
module filter_select_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned AUTO_PERIOD     = 65000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn_enable,
  input  logic                    btn_next,
  input  logic [NUM_FILTERS-1:0]  btn_sel,
  output logic                    filters_en,
  output logic                    select0,
  output logic                    select1,
  output logic                    select2,
  output logic                    select3,
  output logic [FILTER_SEL_W-1:0] cur_sel
);

  if (DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_param_check
    $error("filter_select_ctrl: DEBOUNCE_CYCLES and AUTO_PERIOD must be at least 2");
  end

  logic                   enable_stb, next_stb;
  logic                   enable_lvl, next_lvl;
  logic [NUM_FILTERS-1:0] sel_stb, sel_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enable (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn_enable),
    .level  (enable_lvl),
    .strobe (enable_stb)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn_next),
    .level  (next_lvl),
    .strobe (next_stb)
  );

  for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_db_sel
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn    (btn_sel[i]),
      .level  (sel_lvl[i]),
      .strobe (sel_stb[i])
    );
  end

  // Debounced levels are not needed here; only the press strobes matter.
  logic unused_lvl;
  assign unused_lvl = ^{enable_lvl, next_lvl, sel_lvl};

  fsm_state_e                state_q, state_d;
  logic [FILTER_SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [NUM_FILTERS-1:0]    pulse_q, pulse_d;
  logic                      sel_hit;
  logic [FILTER_SEL_W-1:0]   sel_idx;
  logic                      auto_fire;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    // Descending scan so the lowest pressed index is the one that sticks.
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (sel_stb[i]) begin
        sel_hit = 1'b1;
        sel_idx = FILTER_SEL_W'(i);
      end
    end
  end

`ifdef FILTER_AUTO_CYCLE_EN
  localparam int unsigned AutoW = $clog2(AUTO_PERIOD);
  localparam logic [AutoW-1:0] AutoMax = AutoW'(AUTO_PERIOD - 1);

  logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_fire  = 1'b0;
    if (state_q != ACTIVE || enable_stb || sel_hit || next_stb) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AutoMax) begin
      auto_cnt_d = '0;
      auto_fire  = 1'b1;
    end else begin
      auto_cnt_d = auto_cnt_q + AutoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pulse_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (enable_stb) begin
          // Re-announce the held selection so the filter block resyncs.
          state_d = ACTIVE;
          pulse_d = sel_onehot(cur_sel_q);
        end
      end
      ACTIVE: begin
        if (enable_stb) begin
          state_d = IDLE;
        end else if (sel_hit) begin
          cur_sel_d = sel_idx;
          pulse_d   = sel_onehot(sel_idx);
        end else if (next_stb || auto_fire) begin
          cur_sel_d = cur_sel_q + FILTER_SEL_W'(1);
          pulse_d   = sel_onehot(cur_sel_q + FILTER_SEL_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= SEPIA;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pulse_q   <= pulse_d;
    end
  end

  assign filters_en = (state_q == ACTIVE);
  assign select0    = pulse_q[0];
  assign select1    = pulse_q[1];
  assign select2    = pulse_q[2];
  assign select3    = pulse_q[3];
  assign cur_sel    = cur_sel_q;

endmodule
